// File: rtl/skolem_udiv_ne_check.sv
// skolem_udiv_ne_check
// Sequential checker for the 4-bit bvudiv / != Skolem function block.
// It accepts one (s, t, x) triple per valid/ready transaction and divides
// x by s with a serial restoring divider, one quotient bit per cycle.
// It then emits a registered verdict for the vector and keeps saturating
// pass/fail/vacuous statistics.
//
// Optional feature: define SKOLEM_CHK_FAILCAP_EN to add cap_valid/cap_vec.
// These ports latch the first failing vector seen after reset or clr.
//
// Handshake: a triple transfers on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE, and in_valid is ignored in every other state.
// s/t/x are sampled only on the accepting edge and may change afterwards.
module skolem_udiv_ne_check #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       s,
  input  logic [3:0]       t,
  input  logic [3:0]       x,
  output logic             res_valid,
  output logic [3:0]       res_q,
  output logic             res_pass,
  output logic             res_vac,
  output logic [CNT_W-1:0] checked_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] vac_cnt,
  output logic [1:0]       state_dbg
`ifdef SKOLEM_CHK_FAILCAP_EN
  ,
  output logic             cap_valid,
  output logic [11:0]      cap_vec
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [3:0] s_r;
  logic [3:0] t_r;
  logic [3:0] x_r;
  // The remainder is always < s after a step, so 4 stored bits suffice.
  // The shifted value r_sh carries the fifth bit for the compare.
  logic [3:0] r;
  logic [3:0] qr;
  logic [1:0] k;

  logic [4:0] r_sh;
  logic       ge;
  logic [3:0] r_nx;
  logic [3:0] q_nx;
  logic       ic;

  assign state_dbg = state;

  // One restoring-division step: shift in x[k], subtract s when it fits.
  always_comb begin
    r_sh  = {r, x_r[k]};
    ge    = (r_sh >= {1'b0, s_r});
    r_nx  = ge ? 4'(r_sh - {1'b0, s_r}) : r_sh[3:0];
    q_nx  = qr;
    q_nx[k] = ge;
    ic    = (s_r != 4'd0) || (t_r != 4'hF);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_q     <= 4'd0;
      res_pass  <= 1'b0;
      res_vac   <= 1'b0;
      s_r       <= 4'd0;
      t_r       <= 4'd0;
      x_r       <= 4'd0;
      r         <= 4'd0;
      qr        <= 4'd0;
      k         <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s_r      <= s;
            t_r      <= t;
            x_r      <= x;
            r        <= 4'd0;
            qr       <= 4'd0;
            k        <= 2'd3;
            in_ready <= 1'b0;
            state    <= DIV;
          end
        end
        DIV: begin
          r  <= r_nx;
          qr <= q_nx;
          k  <= k - 2'd1;
          if (k == 2'd0) begin
            // s == 0 makes every step fit, so Q ends at 4'hF without a special path.
            res_valid <= 1'b1;
            res_q     <= q_nx;
            res_vac   <= ~ic;
            res_pass  <= ~ic | (q_nx != t_r);
            state     <= DONE;
          end
        end
        DONE: begin
          res_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          res_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Saturating statistics, updated on the DONE->IDLE edge; clr has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checked_cnt <= '0;
      fail_cnt    <= '0;
      vac_cnt     <= '0;
    end else if (clr) begin
      checked_cnt <= '0;
      fail_cnt    <= '0;
      vac_cnt     <= '0;
    end else if (state == DONE) begin
      if (checked_cnt != '1) checked_cnt <= checked_cnt + CNT_ONE;
      if (!res_pass && (fail_cnt != '1)) fail_cnt <= fail_cnt + CNT_ONE;
      if (res_vac && (vac_cnt != '1)) vac_cnt <= vac_cnt + CNT_ONE;
    end
  end

`ifdef SKOLEM_CHK_FAILCAP_EN
  // Sticky capture of the first failing vector as {t, s, x}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_vec   <= 12'd0;
    end else if (clr) begin
      cap_valid <= 1'b0;
      cap_vec   <= 12'd0;
    end else if ((state == DONE) && !res_pass && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_vec   <= {t_r, s_r, x_r};
    end
  end
`endif

endmodule
